// File: rtl/morse_char_ctrl_pkg.sv
// morse_char_ctrl_pkg
// Shared definitions for the Morse character sequencer: collector state
// encoding, dot/dash symbol values and default parameter values.
// No ports.
package morse_char_ctrl_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int MAX_SYM_DEF  = 5;
    localparam int LEN_W_DEF    = 3;
    localparam int DROP_W_DEF   = 8;
    localparam int WORD_GAP_DEF = 16;

endpackage

// File: rtl/morse_char_ctrl_if.sv
// morse_char_ctrl_if
// Character output slot handshake: one completed character (or word break)
// offered with valid/ready.
//   chr_valid_o  slot holds an entry
//   chr_ready_i  consumer takes the entry while valid is high
//   chr_code_o   symbols, first received in the MSB of the used field
//   chr_len_o    number of symbols
//   chr_ovf_o    character had more symbols than the code can hold
//   word_o       entry is a word break rather than a character
// master: the producer (slot), slave: the consumer.
interface morse_char_ctrl_if
    import morse_char_ctrl_pkg::*;
#(
    parameter int MAX_SYM = MAX_SYM_DEF,
    parameter int LEN_W   = LEN_W_DEF
);
    logic               chr_valid_o;
    logic               chr_ready_i;
    logic [MAX_SYM-1:0] chr_code_o;
    logic [LEN_W-1:0]   chr_len_o;
    logic               chr_ovf_o;
    logic               word_o;

    modport master (
        output chr_valid_o, chr_code_o, chr_len_o, chr_ovf_o, word_o,
        input  chr_ready_i
    );

    modport slave (
        input  chr_valid_o, chr_code_o, chr_len_o, chr_ovf_o, word_o,
        output chr_ready_i
    );
endinterface

// File: rtl/morse_out_slot.sv
// morse_out_slot
// One-entry valid/ready holding register with a saturating drop counter.
// A character load that arrives while the slot is full and not being taken
// is discarded and counted; a word-break load waits until the slot is free
// and is never counted.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ld_chr       load a character this cycle (code/len/ovf)
//   code/len/ovf character contents
//   ld_word      request to load a word break
//   word_ack     word break was loaded this cycle
//   drop_cnt     saturating count of discarded characters
//   out          handshake towards the consumer (master side)
module morse_out_slot
    import morse_char_ctrl_pkg::*;
#(
    parameter int CODE_W = MAX_SYM_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld_chr,
    input  logic [CODE_W-1:0]  code,
    input  logic [LEN_W-1:0]   len,
    input  logic               ovf,
    input  logic               ld_word,
    output logic               word_ack,
    output logic [DROP_W-1:0]  drop_cnt,
    morse_char_ctrl_if.master  out
);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    logic              valid_q;
    logic [CODE_W-1:0] code_q;
    logic [LEN_W-1:0]  len_q;
    logic              ovf_q;
    logic              word_q;
    logic [DROP_W-1:0] drop_q;
    logic              free;

    // Free when empty or being emptied this very cycle.
    assign free     = !valid_q || out.chr_ready_i;
    assign word_ack = ld_word && free && !ld_chr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            code_q  <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            word_q  <= 1'b0;
            drop_q  <= '0;
        end else if (ld_chr) begin
            if (free) begin
                valid_q <= 1'b1;
                code_q  <= code;
                len_q   <= len;
                ovf_q   <= ovf;
                word_q  <= 1'b0;
            end else begin
                drop_q  <= sat_inc(drop_q);
            end
        end else if (word_ack) begin
            valid_q <= 1'b1;
            code_q  <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            word_q  <= 1'b1;
        end else if (valid_q && out.chr_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out.chr_valid_o = valid_q;
    assign out.chr_code_o  = code_q;
    assign out.chr_len_o   = len_q;
    assign out.chr_ovf_o   = ovf_q;
    assign out.word_o      = word_q;
    assign drop_cnt        = drop_q;

endmodule

// File: rtl/morse_char_ctrl.sv
// morse_char_ctrl
// Collects dot/dash events from the pulse/space classifier into a character
// (code + length + overflow flag) and hands each completed character to a
// one-entry valid/ready slot. Symbol capture never stalls on the consumer;
// characters that find the slot occupied are counted as drops.
// Optional feature, macro WORD_GAP_EN: after a character completes, WORD_GAP
// idle cycles produce one word-break entry (word_o = 1, len 0). Without the
// macro no word breaks are generated and word_o stays 0.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   dot_i        short pulse ended
//   dash_i       long pulse ended
//   sym_gap_i    short space ended
//   chr_gap_i    long space ended (character boundary)
//   chr_if       output slot handshake (valid/ready, code, len, ovf, word)
//   busy_o       collection in progress
//   drop_cnt_o   saturating count of characters lost to a full slot
module morse_char_ctrl
    import morse_char_ctrl_pkg::*;
#(
    parameter int MAX_SYM  = MAX_SYM_DEF,
    parameter int LEN_W    = LEN_W_DEF,
    parameter int DROP_W   = DROP_W_DEF,
    parameter int WORD_GAP = WORD_GAP_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dot_i,
    input  logic               dash_i,
    input  logic               sym_gap_i,
    input  logic               chr_gap_i,
    morse_char_ctrl_if.master  chr_if,
    output logic               busy_o,
    output logic [DROP_W-1:0]  drop_cnt_o
);

    state_t             state_q;
    logic [MAX_SYM-1:0] code_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovf_q;

    logic sym_ev;
    logic sym;
    logic chr_done;
    logic ld_word;
    logic word_ack;

    // Dash outranks dot; any symbol masks a gap in the same cycle.
    assign sym_ev   = dot_i || dash_i;
    assign sym      = dash_i ? SYM_DASH : SYM_DOT;
    assign chr_done = (state_q == ST_COLLECT) && chr_gap_i && !sym_ev;
    assign busy_o   = (state_q == ST_COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sym_ev) begin
                        code_q  <= {{(MAX_SYM-1){1'b0}}, sym};
                        len_q   <= LEN_W'(1);
                        ovf_q   <= 1'b0;
                        state_q <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (sym_ev) begin
                        if (len_q < LEN_W'(MAX_SYM)) begin
                            code_q <= {code_q[MAX_SYM-2:0], sym};
                            len_q  <= len_q + LEN_W'(1);
                        end else begin
                            // Extra symbols are discarded; the flag sticks
                            // until the character is handed off.
                            ovf_q  <= 1'b1;
                        end
                    end else if (chr_gap_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef WORD_GAP_EN
    localparam int GAP_W = $clog2(WORD_GAP + 1);

    logic [GAP_W-1:0] gap_cnt_q;
    logic             armed_q;
    logic             pend_q;

    // armed_q: a character has completed and no break has yet been raised
    // for this idle period. A new symbol cancels both the count and any
    // break still waiting for the slot, so a break never lands after the
    // character that follows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_q <= '0;
            armed_q   <= 1'b0;
            pend_q    <= 1'b0;
        end else if (sym_ev) begin
            gap_cnt_q <= '0;
            armed_q   <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            if (chr_done) begin
                armed_q   <= 1'b1;
                gap_cnt_q <= '0;
            end else if (armed_q && state_q == ST_IDLE) begin
                if (gap_cnt_q == GAP_W'(WORD_GAP - 1)) begin
                    pend_q    <= 1'b1;
                    armed_q   <= 1'b0;
                    gap_cnt_q <= '0;
                end else begin
                    gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                end
            end
            if (word_ack) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign ld_word = pend_q;
`else
    assign ld_word = 1'b0;

    logic unused_word;
    assign unused_word = &{1'b0, word_ack, 32'(WORD_GAP)};
`endif

    // A short space carries no information once symbols arrive as events.
    logic unused_sym_gap;
    assign unused_sym_gap = sym_gap_i;

    morse_out_slot #(
        .CODE_W (MAX_SYM),
        .LEN_W  (LEN_W),
        .DROP_W (DROP_W)
    ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_chr   (chr_done),
        .code     (code_q),
        .len      (len_q),
        .ovf      (ovf_q),
        .ld_word  (ld_word),
        .word_ack (word_ack),
        .drop_cnt (drop_cnt_o),
        .out      (chr_if)
    );

endmodule

// File: doc/morse_char_ctrl.md
Name: morse_char_ctrl

Overview:
- Sequencer downstream of the pulse/space classifier.
- Inputs are its single-cycle events: short pulse = dot, long pulse = dash, short space = symbol gap, long space = character gap.
- Gathers dot/dash symbols into a character code and length, then presents each completed character on a one-entry valid/ready output slot.
- Counts characters dropped because the consumer stalled.

Parameters:
MAX_SYM, 5, maximum symbols per character; also the width of the code register
LEN_W, 3, width of the symbol-length field; must hold MAX_SYM
DROP_W, 8, width of the saturating drop counter
WORD_GAP, 16, idle cycles after a character that signal a word break (used only with the optional feature)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
dot_i  in  1  single-cycle pulse: short pulse ended
dash_i  in  1  single-cycle pulse: long pulse ended
sym_gap_i  in  1  single-cycle pulse: short space ended
chr_gap_i  in  1  single-cycle pulse: long space ended (character boundary)
chr_valid_o  out  1  output slot holds a character
chr_ready_i  in  1  consumer accepts the slot when valid is high
chr_code_o  out  MAX_SYM  symbols, first received in MSB of the used field; dot=0, dash=1
chr_len_o  out  LEN_W  number of symbols, 0..MAX_SYM
chr_ovf_o  out  1  character had more than MAX_SYM symbols; code holds the first MAX_SYM
word_o  out  1  slot holds a word break rather than a character
busy_o  out  1  collection in progress (state COLLECT)
drop_cnt_o  out  DROP_W  saturating count of characters lost to a full slot

Behaviour:
- Reset is asynchronous with rst_n low. All outputs go to 0, state to IDLE, and the collection and slot registers clear.
- Event priority when several inputs are high in one cycle: dash > dot > chr_gap > sym_gap. Lower-priority events in that cycle are ignored.
- Collector FSM has two states, IDLE and COLLECT.
- IDLE:
  - dot/dash: code = symbol, len = 1, ovf = 0; go to COLLECT.
  - Gap events are ignored.
- COLLECT:
  - dot/dash with len < MAX_SYM: code = {code, symbol}, len + 1.
  - dot/dash with len = MAX_SYM: symbol discarded, ovf set (sticky until character end).
  - sym_gap: no change.
  - chr_gap: character completes; go to IDLE.
- Output slot:
  - Character completion while the slot is empty, or being emptied this cycle (valid & ready): load code/len/ovf, word = 0, valid = 1 next cycle. Latency from chr_gap_i to chr_valid_o is 1 cycle.
  - Completion while valid & !ready: new character dropped, drop_cnt + 1 saturating at all-ones, slot unchanged.
  - Slot contents are held stable while valid & !ready.
  - valid & ready with no new load: valid = 0 next cycle; data outputs keep their last values.
- Collection continues independently while the slot is full, so a stalled consumer never stalls symbol capture.
- busy_o = (state == COLLECT).

Optional Feature:
Macro WORD_GAP_EN.
- Defined:
  - An idle counter runs in IDLE only after a character completes. It resets on any dot/dash.
  - When it reaches WORD_GAP it raises a pending word break, which loads the slot with code 0, len 0, ovf 0, word = 1 once the slot is free.
  - A word-break load is never counted as a drop.
  - One word break per idle period; after reset no break is issued until a character has completed.
- Undefined: no counter, word_o tied to 0; the port is always present.

Decomposition:
- Shared package: state encoding (ST_IDLE, ST_COLLECT), symbol constants (SYM_DOT=0, SYM_DASH=1), default parameter values.
- One natural sub-module, morse_out_slot: the one-entry valid/ready holding register with drop counter, reusable for other character sources.

Test Plan:
- dot, sym_gap, dash, chr_gap ("A"), ready=1 -> valid one cycle after chr_gap, code[1:0]=01, len=2, ovf=0, word=0.
- Six dashes then chr_gap, MAX_SYM=5 -> code=11111, len=5, ovf=1.
- Two characters with ready=0 throughout -> first held stable, drop_cnt=1; after drop_cnt saturation, further drops leave it at 255.
- chr_gap in the same cycle as valid&ready of the previous character -> new character loaded, valid stays high, no drop.
- rst_n low mid-COLLECT with valid=1 -> all outputs 0 immediately; next dot starts fresh with len=1.
- WORD_GAP_EN, WORD_GAP=16: "E" then 16 idle cycles -> word_o=1 slot with len=0; a dot at idle cycle 15 -> no word break.
